debounce_event_gen: RTL and testbench

- Front-end conditioning stage that sits directly upstream of the modulo-N event counters.
- Takes a raw, bouncing, asynchronous pushbutton or sensor level and synchronises it to CLK.
- Debounces it with a stability counter and emits exactly one clean single-cycle EVENT pulse per confirmed press.
- EVENT drives a counter's clock/event input. Each pulse produces exactly one falling edge, which is one count event.

---
 rtl/debounce_pkg.sv | 26 ++
 rtl/debounce_event_gen_sync2.sv | 32 +++
 rtl/debounce_event_gen.sv | 129 ++++++++++++
 tb/tb_debounce_event_gen.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// ============================================================================
// Module : debounce_pkg
// Brief  : Shared state encoding and default parameters for debounce_event_gen.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package debounce_pkg;

  // Gray-ordered so that IDLE<->WAIT transitions flip a single bit.
  localparam logic [1:0] IDLE_LOW  = 2'b00;
  localparam logic [1:0] WAIT_HIGH = 2'b01;
  localparam logic [1:0] IDLE_HIGH = 2'b11;
  localparam logic [1:0] WAIT_LOW  = 2'b10;

  localparam int unsigned DEF_DB_CYCLES = 50000;
  localparam int unsigned DEF_DB_W      = 16;

  // With this encoding the two qualifying states are exactly those whose bits differ.
  function automatic logic is_wait(input logic [1:0] state);
    return state[1] ^ state[0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_event_gen_sync2.sv
// ============================================================================
// Module : sync2
// Brief  : Two-flop synchroniser with synchronous active-high clear.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync2 (
  input  logic CLK,
  input  logic CLEAR,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge CLK) begin
    if (CLEAR) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

`default_nettype wire

// File: rtl/debounce_event_gen.sv
// ============================================================================
// Module : debounce_event_gen
// Brief  : Synchronise and debounce a raw button; emit one-cycle press/release pulses.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_event_gen
  import debounce_pkg::*;
#(
  parameter int unsigned DB_W      = DEF_DB_W,
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic CLK,
  input  logic CLEAR,
  input  logic BTN_IN,
  output logic EVENT,
  output logic RELEASE,
  output logic LEVEL,
  output logic BUSY
);

  localparam logic [DB_W-1:0] c_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0] c_ONE  = DB_W'(1);
  localparam logic [DB_W-1:0] c_ZERO = '0;

  logic            w_s2;
  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [DB_W-1:0] r_cnt;
  logic [DB_W-1:0] w_cnt_nxt;
  logic            r_event;
  logic            r_release;
  logic            r_level;
  logic            r_busy;
  logic            w_event_nxt;
  logic            w_release_nxt;
  logic            w_level_nxt;

  sync2 u_sync (
    .CLK   (CLK),
    .CLEAR (CLEAR),
    .i_d   (BTN_IN),
    .o_q   (w_s2)
  );

  // The entering sample counts as the first stable cycle, hence cnt<=1 on entry.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_event_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_level_nxt   = r_level;
    case (r_state)
      IDLE_LOW: begin
        if (w_s2) begin
          w_state_nxt = WAIT_HIGH;
          w_cnt_nxt   = c_ONE;
        end else begin
          w_cnt_nxt   = c_ZERO;
        end
      end
      WAIT_HIGH: begin
        if (!w_s2) begin
          w_state_nxt = IDLE_LOW;
          w_cnt_nxt   = c_ZERO;
        end else if (r_cnt == c_LAST) begin
          w_state_nxt = IDLE_HIGH;
          w_level_nxt = 1'b1;
          w_event_nxt = 1'b1;
          w_cnt_nxt   = c_ZERO;
        end else begin
          w_cnt_nxt   = r_cnt + c_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!w_s2) begin
          w_state_nxt = WAIT_LOW;
          w_cnt_nxt   = c_ONE;
        end else begin
          w_cnt_nxt   = c_ZERO;
        end
      end
      WAIT_LOW: begin
        if (w_s2) begin
          w_state_nxt   = IDLE_HIGH;
          w_cnt_nxt     = c_ZERO;
        end else if (r_cnt == c_LAST) begin
          w_state_nxt   = IDLE_LOW;
          w_level_nxt   = 1'b0;
          w_release_nxt = 1'b1;
          w_cnt_nxt     = c_ZERO;
        end else begin
          w_cnt_nxt     = r_cnt + c_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE_LOW;
        w_cnt_nxt   = c_ZERO;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLEAR) begin
      r_state   <= IDLE_LOW;
      r_cnt     <= c_ZERO;
      r_event   <= 1'b0;
      r_release <= 1'b0;
      r_level   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_event   <= w_event_nxt;
      r_release <= w_release_nxt;
      r_level   <= w_level_nxt;
      r_busy    <= is_wait(w_state_nxt);
    end
  end

  assign EVENT   = r_event;
  assign RELEASE = r_release;
  assign LEVEL   = r_level;
  assign BUSY    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_debounce_event_gen.sv
// ============================================================================
// Module : tb_debounce_event_gen
// Brief  : Scoreboard bench for debounce_event_gen with DB_CYCLES=4.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debounce_event_gen;

  localparam int c_DB  = 4;
  localparam int c_LAT = c_DB + 2;  // negedge of drive -> negedge after pulse edge

  typedef struct {
    bit ev;   // 1 = EVENT, 0 = RELEASE
    int cyc;
  } exp_t;

  logic CLK = 1'b0;
  logic CLEAR;
  logic BTN_IN;
  logic EVENT;
  logic RELEASE;
  logic LEVEL;
  logic BUSY;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_event = 0;
  int   div_cnt = 0;
  int   div_out = 0;
  exp_t sb[$];

  debounce_event_gen #(
    .DB_W      (16),
    .DB_CYCLES (c_DB)
  ) dut (
    .CLK     (CLK),
    .CLEAR   (CLEAR),
    .BTN_IN  (BTN_IN),
    .EVENT   (EVENT),
    .RELEASE (RELEASE),
    .LEVEL   (LEVEL),
    .BUSY    (BUSY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Divide-by-5 counter clocked by the falling edge of EVENT.
  always @(negedge EVENT) begin
    if (div_cnt == 4) begin
      div_cnt = 0;
      div_out++;
    end else begin
      div_cnt++;
    end
  end

  // Monitor: pops the scoreboard whenever a pulse appears.
  always @(negedge CLK) begin
    exp_t e;
    if (EVENT === 1'b1 && RELEASE === 1'b1)
      chk("both_pulses", 32'd1, 32'd0);
    if (EVENT === 1'b1) n_event++;
    if (EVENT === 1'b1 || RELEASE === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {31'd0, EVENT}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", {31'd0, EVENT}, {31'd0, e.ev});
        chk("pulse_cycle", cyc, e.cyc);
      end
    end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      chk("missed_pulse_cycle", cyc, e.cyc);
    end
  end

  task automatic drive_btn(input logic v, input bit expect_pulse);
    exp_t e;
    BTN_IN = v;
    if (expect_pulse) begin
      e.ev  = v;
      e.cyc = cyc + c_LAT;
      sb.push_back(e);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    CLEAR  = 1'b1;
    BTN_IN = 1'b0;

    // Reset with input toggling
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("rst_event", {31'd0, EVENT}, 32'd0);
      chk("rst_release", {31'd0, RELEASE}, 32'd0);
      chk("rst_level", {31'd0, LEVEL}, 32'd0);
      chk("rst_busy", {31'd0, BUSY}, 32'd0);
      chk("rst_state", {30'd0, dut.r_state}, 32'd0);
      chk("rst_s1", {31'd0, dut.u_sync.r_s1}, 32'd0);
      BTN_IN = ~BTN_IN;
    end
    BTN_IN = 1'b0;
    @(negedge CLK);
    CLEAR = 1'b0;
    wait_cycles(4);

    // Clean press
    drive_btn(1'b1, 1'b1);
    wait_cycles(2);
    chk("press_busy_early", {31'd0, BUSY}, 32'd0);
    wait_cycles(1);
    chk("press_busy", {31'd0, BUSY}, 32'd1);
    chk("press_level_pending", {31'd0, LEVEL}, 32'd0);
    wait_cycles(2);
    chk("press_level_before", {31'd0, LEVEL}, 32'd0);
    wait_cycles(1);
    chk("press_level", {31'd0, LEVEL}, 32'd1);
    chk("press_busy_done", {31'd0, BUSY}, 32'd0);
    wait_cycles(1);
    chk("press_event_off", {31'd0, EVENT}, 32'd0);
    wait_cycles(5);

    // Release
    drive_btn(1'b0, 1'b1);
    wait_cycles(5);
    chk("rel_level_before", {31'd0, LEVEL}, 32'd1);
    wait_cycles(1);
    chk("rel_level", {31'd0, LEVEL}, 32'd0);
    wait_cycles(5);

    // Bounce: high 3, low 1, high 2, low
    drive_btn(1'b1, 1'b0);
    wait_cycles(3);
    drive_btn(1'b0, 1'b0);
    wait_cycles(1);
    drive_btn(1'b1, 1'b0);
    wait_cycles(2);
    drive_btn(1'b0, 1'b0);
    wait_cycles(10);
    chk("bounce_level", {31'd0, LEVEL}, 32'd0);
    chk("bounce_state", {30'd0, dut.r_state}, 32'd0);
    chk("bounce_busy", {31'd0, BUSY}, 32'd0);

    // Reset mid-qualification, input still held afterwards
    drive_btn(1'b1, 1'b0);
    wait_cycles(4);
    CLEAR = 1'b1;
    wait_cycles(1);
    chk("midclr_busy", {31'd0, BUSY}, 32'd0);
    chk("midclr_level", {31'd0, LEVEL}, 32'd0);
    CLEAR = 1'b0;
    drive_btn(1'b1, 1'b1);
    wait_cycles(8);
    chk("midclr_level_after", {31'd0, LEVEL}, 32'd1);
    drive_btn(1'b0, 1'b1);
    wait_cycles(10);

    // Downstream divide-by-5
    div_cnt = 0;
    div_out = 0;
    n_event = 0;
    for (int p = 0; p < 10; p++) begin
      drive_btn(1'b1, 1'b1);
      wait_cycles(20);
      drive_btn(1'b0, 1'b1);
      wait_cycles(20);
    end
    wait_cycles(5);
    chk("ds_events", n_event, 32'd10);
    chk("ds_div_out", div_out, 32'd2);
    chk("sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
